// File: rtl/dram_pkg.sv
// Shared types and default timing values for the DRAM command timing block.
// Holds the window FSM state encoding, default T_* cycle counts and the counter width.
// No ports; imported by dram_timing_ctrl.
package dram_pkg;

  localparam int CNT_W = 16;

  localparam int DEF_T_RCD   = 4;
  localparam int DEF_T_CWL   = 5;
  localparam int DEF_T_RL    = 6;
  localparam int DEF_T_BURST = 4;
  localparam int DEF_T_WR    = 6;
  localparam int DEF_T_RP    = 4;
  localparam int DEF_T_RFC   = 32;
  localparam int DEF_T_REFI  = 1560;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACT     = 3'd1,
    WR      = 3'd2,
    WR_WAIT = 3'd3,
    RD      = 3'd4,
    PRE     = 3'd5,
    REF     = 3'd6
  } timing_state_t;

endpackage

// File: rtl/timing_signals_if.sv
// Bundle of timing handshakes between the timing controller and its consumers.
// timing_ctrl modport: producer drives every signal; consumer modport observes them.
// All signals are single-bit, registered (clear is a combinational OR of the dones).
interface timing_signals_if;
  logic tACT_done;
  logic tWR_done;
  logic tRD_done;
  logic tPRE_done;
  logic tREF_done;
  logic tWRITE_WAIT_done;
  logic rf_req;
  logic wr_en;
  logic rd_en;
  logic clear;

  modport timing_ctrl (
    output tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done,
           tWRITE_WAIT_done, rf_req, wr_en, rd_en, clear
  );

  modport consumer (
    input tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done,
          tWRITE_WAIT_done, rf_req, wr_en, rd_en, clear
  );
endinterface

// File: rtl/refresh_timer.sv
// Periodic refresh request generator: counts T_REFI cycles then raises rf_req.
// Ports: clk, rst (sync active-high), ref_ack (REF accepted this cycle), rf_req (level).
// rf_req holds until ref_ack; the interval counter freezes while a request is pending.
module refresh_timer #(
  parameter int T_REFI = dram_pkg::DEF_T_REFI,
  parameter int CNT_W  = dram_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_ack,
  output logic rf_req
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(T_REFI - 1);

  logic [CNT_W-1:0] intervalCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      intervalCnt <= '0;
      rf_req      <= 1'b0;
    end else if (ref_ack) begin
      // A refresh (early or requested) restarts the interval from zero.
      intervalCnt <= '0;
      rf_req      <= 1'b0;
    end else if (!rf_req) begin
      if (intervalCnt == LAST) begin
        rf_req <= 1'b1;
      end else begin
        intervalCnt <= intervalCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dram_timing_ctrl.sv
// Times each DRAM command window and pulses the matching *_done one cycle at its end;
// also generates wr_en/rd_en burst windows, clear, busy and the periodic rf_req.
// Ports: CLK, RST (sync active-high), cmd_act/wr/rd/pre/ref strobes, tif (timing_ctrl
// modport), busy, timing_err (only when DRAM_TIMING_ERR_EN is defined).
module dram_timing_ctrl #(
  parameter int T_RCD   = dram_pkg::DEF_T_RCD,
  parameter int T_CWL   = dram_pkg::DEF_T_CWL,
  parameter int T_RL    = dram_pkg::DEF_T_RL,
  parameter int T_BURST = dram_pkg::DEF_T_BURST,
  parameter int T_WR    = dram_pkg::DEF_T_WR,
  parameter int T_RP    = dram_pkg::DEF_T_RP,
  parameter int T_RFC   = dram_pkg::DEF_T_RFC,
  parameter int T_REFI  = dram_pkg::DEF_T_REFI,
  parameter int CNT_W   = dram_pkg::CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic cmd_act,
  input  logic cmd_wr,
  input  logic cmd_rd,
  input  logic cmd_pre,
  input  logic cmd_ref,
  timing_signals_if.timing_ctrl tif,
  output logic busy
`ifdef DRAM_TIMING_ERR_EN
  ,
  output logic timing_err
`endif
);

  import dram_pkg::*;

  // Window loads are T-1 so that done lands exactly T cycles after acceptance.
  localparam logic [CNT_W-1:0] LD_ACT = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_CWL + T_BURST - 1);
  localparam logic [CNT_W-1:0] LD_WW  = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(T_RL + T_BURST - 1);
  localparam logic [CNT_W-1:0] LD_PRE = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_REF = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] LD_BST = CNT_W'(T_BURST - 1);
  // In WR/RD the window counter reads T_BURST exactly one cycle before data starts.
  localparam logic [CNT_W-1:0] BURST_MARK = CNT_W'(T_BURST);

  timing_state_t state, nextState;
  logic [CNT_W-1:0] winCnt, nextWinCnt;
  logic [CNT_W-1:0] burstCnt, nextBurstCnt;
  logic actDone, wrDone, rdDone, preDone, refDone, wwDone;
  logic nextActDone, nextWrDone, nextRdDone, nextPreDone, nextRefDone, nextWwDone;
  logic wrEn, rdEn, nextWrEn, nextRdEn;
  logic refAck;

  assign refAck = (state == IDLE) && cmd_ref;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      winCnt   <= '0;
      burstCnt <= '0;
      actDone  <= 1'b0;
      wrDone   <= 1'b0;
      rdDone   <= 1'b0;
      preDone  <= 1'b0;
      refDone  <= 1'b0;
      wwDone   <= 1'b0;
      wrEn     <= 1'b0;
      rdEn     <= 1'b0;
    end else begin
      state    <= nextState;
      winCnt   <= nextWinCnt;
      burstCnt <= nextBurstCnt;
      actDone  <= nextActDone;
      wrDone   <= nextWrDone;
      rdDone   <= nextRdDone;
      preDone  <= nextPreDone;
      refDone  <= nextRefDone;
      wwDone   <= nextWwDone;
      wrEn     <= nextWrEn;
      rdEn     <= nextRdEn;
    end
  end

  // Window FSM: counter saturates at zero; the done flag is raised the cycle after
  // the counter reaches zero and the FSM leaves the state one cycle after that.
  always_comb begin
    nextState   = state;
    nextWinCnt  = (winCnt != '0) ? (winCnt - CNT_W'(1)) : '0;
    nextActDone = 1'b0;
    nextWrDone  = 1'b0;
    nextRdDone  = 1'b0;
    nextPreDone = 1'b0;
    nextRefDone = 1'b0;
    nextWwDone  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_ref) begin
          nextState  = REF;
          nextWinCnt = LD_REF;
        end else if (cmd_pre) begin
          nextState  = PRE;
          nextWinCnt = LD_PRE;
        end else if (cmd_act) begin
          nextState  = ACT;
          nextWinCnt = LD_ACT;
        end else if (cmd_wr) begin
          nextState  = WR;
          nextWinCnt = LD_WR;
        end else if (cmd_rd) begin
          nextState  = RD;
          nextWinCnt = LD_RD;
        end
      end
      ACT: begin
        if (actDone) nextState = IDLE;
        else if (winCnt == '0) nextActDone = 1'b1;
      end
      PRE: begin
        if (preDone) nextState = IDLE;
        else if (winCnt == '0) nextPreDone = 1'b1;
      end
      REF: begin
        if (refDone) nextState = IDLE;
        else if (winCnt == '0) nextRefDone = 1'b1;
      end
      RD: begin
        if (rdDone) nextState = IDLE;
        else if (winCnt == '0) nextRdDone = 1'b1;
      end
      WR: begin
        // Recovery is timed from the tWR_done cycle, so the counter is reloaded
        // while still in WR; with T_WR=1 recovery completes on entry to WR_WAIT.
        if (wrDone) begin
          nextState = WR_WAIT;
          if (winCnt == '0) nextWwDone = 1'b1;
        end else if (winCnt == '0) begin
          nextWrDone = 1'b1;
          nextWinCnt = LD_WW;
        end
      end
      WR_WAIT: begin
        if (wwDone) nextState = IDLE;
        else if (winCnt == '0) nextWwDone = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  // Burst windows: opened from the window counter, length counted by burstCnt.
  always_comb begin
    nextBurstCnt = burstCnt;
    nextWrEn     = wrEn;
    nextRdEn     = rdEn;
    if (wrEn || rdEn) begin
      if (burstCnt == '0) begin
        nextWrEn = 1'b0;
        nextRdEn = 1'b0;
      end else begin
        nextBurstCnt = burstCnt - CNT_W'(1);
      end
    end else if ((state == WR) && !wrDone && (winCnt == BURST_MARK)) begin
      // !wrDone keeps the recovery reload from reopening the write burst.
      nextWrEn     = 1'b1;
      nextBurstCnt = LD_BST;
    end else if ((state == RD) && (winCnt == BURST_MARK)) begin
      nextRdEn     = 1'b1;
      nextBurstCnt = LD_BST;
    end
  end

  refresh_timer #(
    .T_REFI (T_REFI),
    .CNT_W  (CNT_W)
  ) uRefresh (
    .clk     (CLK),
    .rst     (RST),
    .ref_ack (refAck),
    .rf_req  (tif.rf_req)
  );

  assign tif.tACT_done        = actDone;
  assign tif.tWR_done         = wrDone;
  assign tif.tRD_done         = rdDone;
  assign tif.tPRE_done        = preDone;
  assign tif.tREF_done        = refDone;
  assign tif.tWRITE_WAIT_done = wwDone;
  assign tif.wr_en            = wrEn;
  assign tif.rd_en            = rdEn;
  assign tif.clear            = actDone | wrDone | rdDone | preDone | refDone | wwDone;
  assign busy                 = (state != IDLE);

`ifdef DRAM_TIMING_ERR_EN
  logic [4:0] strobes;
  assign strobes = {cmd_ref, cmd_pre, cmd_act, cmd_wr, cmd_rd};

  always_ff @(posedge CLK) begin
    if (RST) begin
      timing_err <= 1'b0;
    end else if (((strobes != '0) && busy) || ($countones(strobes) > 1)) begin
      timing_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Scoreboard bench for dram_timing_ctrl (T_REFI=100): stimulus pushes expected
// (event, cycle) pairs; a negedge monitor matches every observed event against them.
// Cycle 0 is the period following the last clock edge that sampled RST high.
module tb_dram_timing_ctrl;

  localparam int K_ACT = 0, K_WR = 1, K_RD = 2, K_PRE = 3, K_REF = 4, K_WW = 5;
  localparam int K_CLR = 6, K_WREN = 7, K_RDEN = 8, K_RFUP = 9, K_RFDN = 10;
  localparam int K_BUP = 11, K_BDN = 12;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic cmd_act, cmd_wr, cmd_rd, cmd_pre, cmd_ref;
  logic busy;
`ifdef DRAM_TIMING_ERR_EN
  logic timing_err;
`endif

  timing_signals_if tif ();

  dram_timing_ctrl #(.T_REFI(100)) dut (
    .CLK     (clk),
    .RST     (rst),
    .cmd_act (cmd_act),
    .cmd_wr  (cmd_wr),
    .cmd_rd  (cmd_rd),
    .cmd_pre (cmd_pre),
    .cmd_ref (cmd_ref),
    .tif     (tif),
    .busy    (busy)
`ifdef DRAM_TIMING_ERR_EN
    ,
    .timing_err (timing_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  ev_t   expQ[$];
  int    passCnt  = 0;
  int    checkCnt = 0;
  bit    monOn    = 1'b0;
  logic  prevBusy = 1'b0;
  logic  prevRf   = 1'b0;
  string kindName [13] = '{"tACT_done", "tWR_done", "tRD_done", "tPRE_done",
                           "tREF_done", "tWRITE_WAIT_done", "clear", "wr_en",
                           "rd_en", "rf_req_rise", "rf_req_fall", "busy_rise",
                           "busy_fall"};

  task automatic expectEv(input int k, input int c);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    expQ.push_back(e);
  endtask

  task automatic expectRange(input int k, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) expectEv(k, c);
  endtask

  // Monitor side: an observed event must match a pending expectation exactly.
  task automatic seen(input int k);
    int idx;
    idx = -1;
    for (int i = 0; i < expQ.size(); i++) begin
      if (idx < 0 && expQ[i].kind == k && expQ[i].cyc == cyc) idx = i;
    end
    checkCnt++;
    if (idx >= 0) begin
      passCnt++;
      expQ.delete(idx);
    end else begin
      $display("FAIL %s at cycle %0d: observed 1, required 0 (unexpected)", kindName[k], cyc);
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (tif.tACT_done)        seen(K_ACT);
      if (tif.tWR_done)         seen(K_WR);
      if (tif.tRD_done)         seen(K_RD);
      if (tif.tPRE_done)        seen(K_PRE);
      if (tif.tREF_done)        seen(K_REF);
      if (tif.tWRITE_WAIT_done) seen(K_WW);
      if (tif.clear)            seen(K_CLR);
      if (tif.wr_en)            seen(K_WREN);
      if (tif.rd_en)            seen(K_RDEN);
      if (tif.rf_req && !prevRf) seen(K_RFUP);
      if (!tif.rf_req && prevRf) seen(K_RFDN);
      if (busy && !prevBusy)    seen(K_BUP);
      if (!busy && prevBusy)    seen(K_BDN);
      prevBusy = busy;
      prevRf   = tif.rf_req;
    end
  end

  task automatic waitCyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      checkCnt++;
      $display("FAIL wait_cycle: reached %0d, required %0d", cyc, n);
    end
  endtask

  // m = {ref, pre, act, wr, rd}; strobe is sampled by the edge that starts cycle k.
  task automatic strobeAt(input int k, input logic [4:0] m);
    waitCyc(k - 1);
    {cmd_ref, cmd_pre, cmd_act, cmd_wr, cmd_rd} = m;
    @(negedge clk);
    {cmd_ref, cmd_pre, cmd_act, cmd_wr, cmd_rd} = 5'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passCnt, checkCnt);
    $fatal(1);
  end

  initial begin
    logic [10:0] outs;
    rst = 1'b1;
    {cmd_ref, cmd_pre, cmd_act, cmd_wr, cmd_rd} = 5'b0;
    repeat (3) @(negedge clk);

    outs = {busy, tif.tACT_done, tif.tWR_done, tif.tRD_done, tif.tPRE_done,
            tif.tREF_done, tif.tWRITE_WAIT_done, tif.rf_req, tif.wr_en,
            tif.rd_en, tif.clear};
    checkCnt++;
    if (outs == 11'b0) passCnt++;
    else $display("FAIL reset_state: outputs %b, required all 0", outs);
    monOn = 1'b1;
    rst   = 1'b0;

    // ACT at 10
    expectEv(K_BUP, 10); expectEv(K_ACT, 14); expectEv(K_CLR, 14); expectEv(K_BDN, 15);
    strobeAt(10, 5'b00100);

    // WR at 20: write burst, tWR_done, then recovery
    expectEv(K_BUP, 20); expectRange(K_WREN, 25, 28);
    expectEv(K_WR, 29); expectEv(K_CLR, 29);
    expectEv(K_WW, 35); expectEv(K_CLR, 35); expectEv(K_BDN, 36);
    strobeAt(20, 5'b00010);

    // RD at 40; ACT at 45 lands mid-window and must be dropped
    expectEv(K_BUP, 40); expectRange(K_RDEN, 46, 49);
    expectEv(K_RD, 50); expectEv(K_CLR, 50); expectEv(K_BDN, 51);
    strobeAt(40, 5'b00001);
    strobeAt(45, 5'b00100);
`ifdef DRAM_TIMING_ERR_EN
    checkCnt++;
    if (timing_err === 1'b1) passCnt++;
    else $display("FAIL timing_err_busy_strobe: got %b, required 1", timing_err);
`endif

    // PRE and ACT together at 60: PRE wins
    expectEv(K_BUP, 60); expectEv(K_PRE, 64); expectEv(K_CLR, 64); expectEv(K_BDN, 65);
    strobeAt(60, 5'b01100);

    // Refresh request rises at 100 and is held through ACT and RD windows
    expectEv(K_RFUP, 100);
    expectEv(K_BUP, 110); expectEv(K_ACT, 114); expectEv(K_CLR, 114); expectEv(K_BDN, 115);
    strobeAt(110, 5'b00100);
    expectEv(K_BUP, 118); expectRange(K_RDEN, 124, 127);
    expectEv(K_RD, 128); expectEv(K_CLR, 128); expectEv(K_BDN, 129);
    strobeAt(118, 5'b00001);

    // REF at 130 acknowledges the request; next request one interval later
    expectEv(K_RFDN, 130); expectEv(K_BUP, 130);
    expectEv(K_REF, 162); expectEv(K_CLR, 162); expectEv(K_BDN, 163);
    expectEv(K_RFUP, 230);
    strobeAt(130, 5'b10000);

    // WR and RD together at 240: WR wins
    expectEv(K_BUP, 240); expectRange(K_WREN, 245, 248);
    expectEv(K_WR, 249); expectEv(K_CLR, 249);
    expectEv(K_WW, 255); expectEv(K_CLR, 255); expectEv(K_BDN, 256);
    strobeAt(240, 5'b00011);

    // WR at 300, reset lands mid-burst at the edge that would start cycle 307
    expectEv(K_BUP, 300); expectRange(K_WREN, 305, 306);
    strobeAt(300, 5'b00010);
    waitCyc(306);
    expectEv(K_BDN, 0); expectEv(K_RFDN, 0);
    expectEv(K_RFUP, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waitCyc(105);

    foreach (expQ[i]) begin
      checkCnt++;
      $display("FAIL %s at cycle %0d: observed 0, required 1 (missing)",
               kindName[expQ[i].kind], expQ[i].cyc);
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
